mul_seq: RTL and testbench



---
 rtl/mul_seq_pkg.sv | 27 ++
 rtl/mul_seq.sv | 99 +++++++++
 tb/tb_mul_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_seq_pkg.sv
// Shared CPU definitions for the sequential multiplier.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the multiplier FSM state encoding, the default operand width and the
// iteration-counter width derived from it.
package mul_seq_pkg;

    // Default operand width; the product is twice this wide.
    localparam int MUL_WIDTH = 16;

    // Counter width needed to count WIDTH-1 down to 0 for a given width.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // Counter width for the default operand width.
    localparam int MUL_CNT_W = cnt_width(MUL_WIDTH);

    // Multiplier FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_seq.sv
// Radix-2 shift-add unsigned multiplier for the ALU.
// Latency: fixed WIDTH+1 cycles from the start cycle to the done pulse (17 for WIDTH=16).
// Backpressure: none; start is ignored while busy, back-to-back start is accepted in the done cycle.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   start      request pulse, sampled on the rising edge in IDLE or DONE
//   mul1/mul2  unsigned magnitude operands, captured on an accepted start
//   mulresult  registered 2*WIDTH-bit product, held until the next done
//   busy       high while the shift-add iterations run
//   done       single-cycle pulse; mulresult is valid in the same cycle
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   mul1,
    input  logic [WIDTH-1:0]   mul2,
    output logic [2*WIDTH-1:0] mulresult,
    output logic               busy,
    output logic               done
);

    // Reuse the package value for the default width, derive it otherwise.
    localparam int CW = (WIDTH == MUL_WIDTH) ? MUL_CNT_W : cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    mul_state_t         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;   // multiplicand, shifted left each iteration
    logic [WIDTH-1:0]   mplier;  // multiplier, shifted right each iteration

    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] sum;
    logic               accept;

    // The single adder of the datapath: partial product selected by the
    // current multiplier LSB.
    always_comb begin
        addend = mplier[0] ? mcand : '0;
        sum    = acc + addend;
    end

    // A new request is taken in IDLE, and also in DONE so that a start held
    // during the done pulse chains straight into the next multiplication.
    assign accept = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            mulresult <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        mcand  <= {{WIDTH{1'b0}}, mul1};
                        mplier <= mul2;
                        acc    <= '0;
                        cnt    <= CNT_LOAD;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    // Always exactly WIDTH iterations, even for zero operands,
                    // so the ALU sees a fixed latency.
                    acc    <= sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    if (cnt == '0) begin
                        // Product is committed only here, so it holds stable
                        // through the next whole multiplication.
                        mulresult <= sum;
                        state     <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status outputs decode the state register only: no input-to-output path.
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq with a scoreboard of expected products.
// Latency: checks done arrives exactly 17 cycles after the start cycle.
// Backpressure: exercises ignored start while busy and back-to-back start in done.
module tb_mul_seq;

    localparam int W = 16;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   mul1;
    logic [W-1:0]   mul2;
    logic [2*W-1:0] mulresult;
    logic           busy;
    logic           done;

    typedef struct {
        logic [2*W-1:0] prod;
        int             cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_chk;
    int   n_fail;
    logic prev_done;

    mul_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mul1      (mul1),
        .mul2      (mul2),
        .mulresult (mulresult),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance n cycles, leaving the bench just after the rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a one-cycle start from the current (post-edge) cycle and record
    // the expected product and done cycle. Operands are scrambled afterwards
    // so a design that does not capture them gets caught.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        mul1   = a;
        mul2   = b;
        start  = 1'b1;
        e.prod = (2*W)'(a) * (2*W)'(b);
        e.cyc  = cyc + 17;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        mul1  = W'($urandom);
        mul2  = W'($urandom);
    endtask

    // Count busy cycles until done shows up, bounded.
    task automatic wait_done(input string tag, output int nbusy);
        bit seen;
        nbusy = 0;
        seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) seen = 1'b1;
        end
        if (!seen) check({tag, "_timeout"}, 64'(0), 64'(1));
    endtask

    // Output monitor: every done pops the scoreboard and checks product,
    // latency, pulse width and that busy is low in the done cycle.
    always @(negedge clk) begin
        if (rst) begin
            prev_done <= 1'b0;
        end else begin
            if (done) begin
                check("done_width", 64'(prev_done), 64'(0));
                check("busy_in_done", 64'(busy), 64'(0));
                if (sb.size() == 0) begin
                    check("spurious_done", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("product", 64'(mulresult), 64'(e.prod));
                    check("latency", 64'(cyc), 64'(e.cyc));
                end
            end
            prev_done <= done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        start  = 1'b0;
        mul1   = '0;
        mul2   = '0;

        // Reset state
        step(3);
        @(negedge clk);
        check("rst_mulresult", 64'(mulresult), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));

        // Start accepted on the first edge after reset release; 3*5
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(16'd3, 16'd5);
        wait_done("t3x5", nb);
        check("t3x5_busy_cycles", 64'(nb), 64'(16));
        step(3);

        // Maximum operands
        issue(16'hFFFF, 16'hFFFF);
        wait_done("tmax", nb);
        check("tmax_busy_cycles", 64'(nb), 64'(16));
        step(2);

        // Zero operand: full latency, previous product held meanwhile
        issue(16'h0000, 16'h1234);
        step(8);
        check("hold_prev_result", 64'(mulresult), 64'h0000_0000_FFFE_0001);
        check("busy_mid_run", 64'(busy), 64'(1));
        wait_done("tzero", nb);
        check("tzero_busy_cycles", 64'(nb), 64'(15 - 7));
        step(2);

        // Start re-pulsed during RUN is ignored
        issue(16'h1234, 16'h0003);
        step(4);
        mul1  = 16'd7;
        mul2  = 16'd7;
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_done("tign", nb);
        step(25);

        // Reset mid-RUN aborts immediately, no done afterwards
        issue(16'h00AB, 16'h00CD);
        step(7);
        rst = 1'b1;
        #2;
        check("abort_mulresult", 64'(mulresult), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        sb.delete();
        step(2);
        rst = 1'b0;
        step(25);
        issue(16'd2, 16'd9);
        wait_done("t2x9", nb);
        check("t2x9_busy_cycles", 64'(nb), 64'(16));
        step(2);

        // Back-to-back: start held in the done cycle
        issue(16'h0011, 16'h0022);
        step(16);
        check("b2b_in_done", 64'(done), 64'(1));
        issue(16'h0100, 16'h0100);
        wait_done("tb2b", nb);
        check("tb2b_busy_cycles", 64'(nb), 64'(16));
        check("tb2b_result", 64'(mulresult), 64'h0000_0000_0001_0000);
        step(25);

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
